// File: rtl/regfile_pkg.sv
// Shared definitions for the two-read/one-write register file.
//
// Contents:
//   REGFILE_WIDTH / REGFILE_DEPTH  default data width and register count
//   REGFILE_MAX_DEPTH              largest supported register count
//   regfile_addr_t                 address type for the default depth
//   popcount()                     number of set bits, used for busy_cnt

package regfile_pkg;

    localparam int unsigned REGFILE_WIDTH     = 16;
    localparam int unsigned REGFILE_DEPTH     = 16;
    localparam int unsigned REGFILE_MAX_DEPTH = 256;

    typedef logic [$clog2(REGFILE_DEPTH)-1:0] regfile_addr_t;

    // Callers zero-extend their busy vector to REGFILE_MAX_DEPTH bits.
    function automatic int unsigned popcount(input logic [REGFILE_MAX_DEPTH-1:0] bits);
        int unsigned n;
        n = 0;
        for (int i = 0; i < REGFILE_MAX_DEPTH; i++) begin
            n += {31'b0, bits[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for regfile_2r1w_sb.
//
// Tracks one busy bit per register. A lock marks its register busy, a write releases its
// register; when both hit the same register in one cycle the lock wins. Also reports, for
// two read addresses, whether the register is still busy once this cycle's release is
// applied, and keeps a registered count of busy registers.
//
// Optional feature: REGFILE_ZERO_REG_EN -- locks on register 0 are ignored.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   wr_en_i, wr_addr_i   write (release) request
//   lock_en_i, lock_addr_i  lock request
//   rd_addr_i, rs_addr_i addresses to look up
//   rd_busy_o, rs_busy_o busy after release, before lock (combinational)
//   busy_cnt_o           registered number of busy registers

module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned  DEPTH  = REGFILE_DEPTH,
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic              lock_en_i,
    input  logic [ADDR_W-1:0] lock_addr_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    output logic              rd_busy_o,
    output logic              rs_busy_o,
    output logic [CNT_W-1:0]  busy_cnt_o
);

    localparam logic [ADDR_W:0] DepthA = (ADDR_W + 1)'(DEPTH);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [CNT_W-1:0] busy_cnt_q;
    logic             release_ok, lock_ok;

    always_comb begin
        release_ok = wr_en_i && ({1'b0, wr_addr_i} < DepthA);
        lock_ok    = lock_en_i && ({1'b0, lock_addr_i} < DepthA);
`ifdef REGFILE_ZERO_REG_EN
        lock_ok    = lock_ok && (lock_addr_i != '0);
`endif
        busy_d = busy_q;
        if (release_ok) busy_d[wr_addr_i] = 1'b0;
        // Applied last so a same-cycle lock (new producer) overrides the release.
        if (lock_ok) busy_d[lock_addr_i] = 1'b1;
    end

    // Out-of-range addresses are never busy; a same-cycle write releases the register.
    always_comb begin
        rd_busy_o = 1'b0;
        rs_busy_o = 1'b0;
        if ({1'b0, rd_addr_i} < DepthA) begin
            rd_busy_o = busy_q[rd_addr_i] && !(release_ok && (wr_addr_i == rd_addr_i));
        end
        if ({1'b0, rs_addr_i} < DepthA) begin
            rs_busy_o = busy_q[rs_addr_i] && !(release_ok && (wr_addr_i == rs_addr_i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= CNT_W'(popcount(REGFILE_MAX_DEPTH'(busy_d)));
        end
    end

    assign busy_cnt_o = busy_cnt_q;

endmodule

// File: rtl/regfile_2r1w_sb.sv
// Two-read/one-write register file with registered reads, write-to-read bypass and a
// per-register busy scoreboard.
//
// Optional feature: REGFILE_ZERO_REG_EN -- register 0 reads as 0, ignores writes, is
// never forwarded by the bypass and can never be locked.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   rd_en, rd_addr       read port rd
//   rs_en, rs_addr       read port rs
//   wr_en, wr_addr, wr_data  write port; a write also releases busy[wr_addr]
//   lock_en, lock_addr   mark a register busy (destination issued)
//   rd_data, rs_data     registered read data
//   valid                registered: every enabled read returned non-busy data
//   busy_cnt             registered number of busy registers

module regfile_2r1w_sb
    import regfile_pkg::*;
#(
    parameter int unsigned  WIDTH  = REGFILE_WIDTH,
    parameter int unsigned  DEPTH  = REGFILE_DEPTH,
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rs_en,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              lock_en,
    input  logic [ADDR_W-1:0] lock_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic [WIDTH-1:0]  rs_data,
    output logic              valid,
    output logic [CNT_W-1:0]  busy_cnt
);

    localparam logic [ADDR_W:0] DepthA = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q, rd_data_d, rs_data_q, rs_data_d;
    logic [WIDTH-1:0] rd_val, rs_val;
    logic             valid_q, valid_d;
    logic             wr_ok;
    logic             rd_busy, rs_busy;

    regfile_scoreboard #(
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .lock_en_i   (lock_en),
        .lock_addr_i (lock_addr),
        .rd_addr_i   (rd_addr),
        .rs_addr_i   (rs_addr),
        .rd_busy_o   (rd_busy),
        .rs_busy_o   (rs_busy),
        .busy_cnt_o  (busy_cnt)
    );

    always_comb begin
        wr_ok = wr_en && ({1'b0, wr_addr} < DepthA);
`ifdef REGFILE_ZERO_REG_EN
        wr_ok = wr_ok && (wr_addr != '0);
`endif

        // Read muxes: out-of-range returns 0, a same-cycle write is forwarded.
        rd_val = '0;
        rs_val = '0;
        if ({1'b0, rd_addr} < DepthA) rd_val = mem_q[rd_addr];
        if ({1'b0, rs_addr} < DepthA) rs_val = mem_q[rs_addr];
`ifdef REGFILE_ZERO_REG_EN
        if (rd_addr == '0) rd_val = '0;
        if (rs_addr == '0) rs_val = '0;
`endif
        if (wr_ok && (wr_addr == rd_addr)) rd_val = wr_data;
        if (wr_ok && (wr_addr == rs_addr)) rs_val = wr_data;

        rd_data_d = rd_en ? rd_val : rd_data_q;
        rs_data_d = rs_en ? rs_val : rs_data_q;
        valid_d   = (rd_en || rs_en) && !(rd_en && rd_busy) && !(rs_en && rs_busy);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
            rs_data_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            rs_data_q <= rs_data_d;
            valid_q   <= valid_d;
        end
    end

    assign rd_data = rd_data_q;
    assign rs_data = rs_data_q;
    assign valid   = valid_q;

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Self-checking bench for regfile_2r1w_sb. Uses a non-power-of-2 depth so that
// out-of-range addresses are exercised. Honours REGFILE_ZERO_REG_EN when defined.

module tb_regfile_2r1w_sb;

    localparam int W  = 16;
    localparam int D  = 12;
    localparam int AW = $clog2(D);
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_en, rs_en, wr_en, lock_en;
    logic [AW-1:0] rd_addr, rs_addr, wr_addr, lock_addr;
    logic [W-1:0]  wr_data;
    logic [W-1:0]  rd_data, rs_data;
    logic          valid;
    logic [CW-1:0] busy_cnt;

    always #5 clk = ~clk;

    regfile_2r1w_sb #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rs_en     (rs_en),
        .rs_addr   (rs_addr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .lock_en   (lock_en),
        .lock_addr (lock_addr),
        .rd_data   (rd_data),
        .rs_data   (rs_data),
        .valid     (valid),
        .busy_cnt  (busy_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit         zero_reg;
    logic [W-1:0] m_mem [D];
    bit         m_busy [D];
    logic [W-1:0] e_rd, e_rs;
    logic       e_valid;
    int         e_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] m_read(input int a);
        if (a >= D) return '0;
        if (zero_reg && a == 0) return '0;
        if (wr_en && int'(wr_addr) == a) return wr_data;
        return m_mem[a];
    endfunction

    function automatic bit m_busy_eff(input int a);
        if (a >= D) return 1'b0;
        if (wr_en && int'(wr_addr) == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
        e_rd = '0; e_rs = '0; e_valid = 1'b0; e_cnt = 0;
    endtask

    task automatic idle();
        rd_en = 0; rs_en = 0; wr_en = 0; lock_en = 0;
        rd_addr = '0; rs_addr = '0; wr_addr = '0; lock_addr = '0; wr_data = '0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "/rd_data"},  32'(rd_data),  32'(e_rd));
        check({tag, "/rs_data"},  32'(rs_data),  32'(e_rs));
        check({tag, "/valid"},    32'(valid),    32'(e_valid));
        check({tag, "/busy_cnt"}, 32'(busy_cnt), 32'(e_cnt));
    endtask

    // Apply current inputs for one clock edge, advance the model, compare all outputs.
    task automatic cycle(input string tag);
        logic [W-1:0] n_rd, n_rs;
        bit           n_valid;
        int           wa, la;
        n_rd    = rd_en ? m_read(int'(rd_addr)) : e_rd;
        n_rs    = rs_en ? m_read(int'(rs_addr)) : e_rs;
        n_valid = (rd_en || rs_en) && !(rd_en && m_busy_eff(int'(rd_addr)))
                  && !(rs_en && m_busy_eff(int'(rs_addr)));
        wa = int'(wr_addr);
        la = int'(lock_addr);
        if (wr_en && wa < D) begin
            if (!(zero_reg && wa == 0)) m_mem[wa] = wr_data;
            m_busy[wa] = 1'b0;
        end
        if (lock_en && la < D && !(zero_reg && la == 0)) m_busy[la] = 1'b1;
        e_rd = n_rd; e_rs = n_rs; e_valid = n_valid;
        e_cnt = 0;
        for (int i = 0; i < D; i++) e_cnt += int'(m_busy[i]);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
`ifdef REGFILE_ZERO_REG_EN
        zero_reg = 1'b1;
`else
        zero_reg = 1'b0;
`endif
        idle();
        model_reset();
        rst_n = 1'b0;
        #12;
        check_outputs("por");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset mid-stream after writing r3
        wr_en = 1; wr_addr = 3; wr_data = 16'h00FF; cycle("wr_r3"); idle();
        rd_en = 1; rd_addr = 3; lock_en = 1; lock_addr = 2; cycle("rd_r3");
        check("rd_r3_value", 32'(rd_data), 32'h00FF);
        wr_en = 1; wr_addr = 4; wr_data = 16'h5555;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_async");
        @(posedge clk); @(posedge clk); #1;
        check_outputs("rst_hold");
        rst_n = 1'b1;
        idle();
        rd_en = 1; rd_addr = 3; cycle("after_rst");
        check("after_rst_r3", 32'(rd_data), 32'h0000);
        check("after_rst_valid", 32'(valid), 32'd1);

        // Write then read
        idle(); wr_en = 1; wr_addr = 0; wr_data = 16'h00FF; cycle("wr_r0");
        idle(); rd_en = 1; rd_addr = 0; rs_en = 1; rs_addr = 1; cycle("rd_r0_rs_r1");
        check("rd_r0_value", 32'(rd_data), zero_reg ? 32'h0 : 32'h00FF);
        check("rs_r1_value", 32'(rs_data), 32'h0000);

        // Bypass
        idle(); wr_en = 1; wr_addr = 1; wr_data = 16'hFF00; rd_en = 1; rd_addr = 1;
        cycle("bypass");
        check("bypass_value", 32'(rd_data), 32'hFF00);

        // Hazard on r5
        idle(); lock_en = 1; lock_addr = 5; cycle("lock_r5");
        idle(); rs_en = 1; rs_addr = 5; cycle("rd_busy_r5");
        check("hazard_valid", 32'(valid), 32'd0);
        check("hazard_cnt", 32'(busy_cnt), 32'd1);
        idle(); rs_en = 1; rs_addr = 5; wr_en = 1; wr_addr = 5; wr_data = 16'h1234;
        cycle("release_r5");
        check("release_data", 32'(rs_data), 32'h1234);
        check("release_valid", 32'(valid), 32'd1);
        check("release_cnt", 32'(busy_cnt), 32'd0);

        // Lock/write collision on r7, then relock an already-busy register
        idle(); lock_en = 1; lock_addr = 7; wr_en = 1; wr_addr = 7; wr_data = 16'hABCD;
        cycle("collide_r7");
        check("collide_cnt", 32'(busy_cnt), 32'd1);
        idle(); rd_en = 1; rd_addr = 7; cycle("rd_r7");
        check("collide_data", 32'(rd_data), 32'hABCD);
        check("collide_valid", 32'(valid), 32'd0);
        idle(); lock_en = 1; lock_addr = 7; cycle("relock_r7");
        check("relock_cnt", 32'(busy_cnt), 32'd1);
        idle(); wr_en = 1; wr_addr = 7; wr_data = 16'hABCD; cycle("free_r7");

        // Register 0 behaviour
        idle(); wr_en = 1; wr_addr = 0; wr_data = 16'hBEEF; lock_en = 1; lock_addr = 0;
        cycle("wr_lock_r0");
        idle(); rd_en = 1; rd_addr = 0; cycle("rd_r0");
        check("r0_data", 32'(rd_data), zero_reg ? 32'h0000 : 32'hBEEF);
        check("r0_valid", 32'(valid), zero_reg ? 32'd1 : 32'd0);
        check("r0_cnt", 32'(busy_cnt), zero_reg ? 32'd0 : 32'd1);

        // Out-of-range addresses
        idle(); wr_en = 1; wr_addr = 13; wr_data = 16'h7777; lock_en = 1; lock_addr = 14;
        rd_en = 1; rd_addr = 13; cycle("oor_bypass");
        check("oor_data", 32'(rd_data), 32'h0000);
        idle(); rd_en = 1; rd_addr = 13; rs_en = 1; rs_addr = 15; cycle("oor_read");
        check("oor_valid", 32'(valid), 32'd1);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            rd_en     = ($urandom_range(0, 3) != 0);
            rs_en     = ($urandom_range(0, 3) != 0);
            wr_en     = ($urandom_range(0, 1) != 0);
            lock_en   = ($urandom_range(0, 2) == 0);
            rd_addr   = AW'($urandom_range(0, 2 ** AW - 1));
            rs_addr   = ($urandom_range(0, 7) == 0) ? rd_addr : AW'($urandom_range(0, 2 ** AW - 1));
            wr_addr   = ($urandom_range(0, 3) == 0) ? rd_addr : AW'($urandom_range(0, 2 ** AW - 1));
            lock_addr = ($urandom_range(0, 5) == 0) ? wr_addr : AW'($urandom_range(0, 2 ** AW - 1));
            wr_data   = W'($urandom);
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
